trace_capture_fifo: RTL and testbench

// Consumer end of the CPU write-back trace port (pc, RegWrite/RegAddr/RegData, MemWrite/MemAddr/MemData).

---
 rtl/trace_capture_fifo.sv | 127 ++++++++++++
 tb/tb_trace_capture_fifo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/trace_capture_fifo.sv
// trace_capture_fifo
// Captures register/memory write-back events from the core trace port into a
// first-word-fall-through FIFO and drains them in program order over a
// valid/ready stream. The core is never stalled: events that do not fit are
// counted as dropped.
//
// Stream handshake: ev_valid is high whenever the FIFO holds an entry and the
// ev_* fields show that head entry; the entry is consumed at the rising clk
// edge where ev_valid && ev_ready are both 1. ev_ready while empty is ignored.
module trace_capture_fifo #(
   parameter int DEPTH  = 16,
   parameter int DROP_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cap_en,
   input  logic [31:0]              pc,
   input  logic                     RegWrite,
   input  logic [4:0]               RegAddr,
   input  logic [31:0]              RegData,
   input  logic                     MemWrite,
   input  logic [31:0]              MemAddr,
   input  logic [31:0]              MemData,
   output logic                     ev_valid,
   input  logic                     ev_ready,
   output logic                     ev_type,
   output logic [31:0]              ev_pc,
   output logic [31:0]              ev_addr,
   output logic [31:0]              ev_data,
   output logic [$clog2(DEPTH):0]   ev_count,
   output logic                     overflow,
   output logic [DROP_W-1:0]        drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // Entry storage, one array per field
   logic        typeMem [DEPTH];
   logic [31:0] pcMem   [DEPTH];
   logic [31:0] addrMem [DEPTH];
   logic [31:0] dataMem [DEPTH];

   logic [AW-1:0] wrPtr;
   logic [AW-1:0] rdPtr;
   logic [AW-1:0] memSlot;
   logic          regEv;
   logic          memEv;
   logic          popEn;
   logic          pushEn;
   logic          dropEn;
   logic [CW:0]   needW;
   logic [CW:0]   freeW;
   logic [DROP_W:0] dropSum;

   // Event qualification, space check and atomic pair push decision
   always_comb begin
      regEv   = cap_en && RegWrite && (RegAddr != 5'd0);
      memEv   = cap_en && MemWrite;
      popEn   = ev_valid && ev_ready;
      needW   = (CW+1)'(regEv) + (CW+1)'(memEv);
      // A pop at this edge frees its slot for a push at the same edge
      freeW   = (CW+1)'(DEPTH) - (CW+1)'(ev_count) + (CW+1)'(popEn);
      pushEn  = (needW != '0) && (needW <= freeW);
      dropEn  = needW > freeW;
      // The mem event lands behind the reg event when both are present
      memSlot = wrPtr + AW'(regEv);
      dropSum = (DROP_W+1)'(drop_cnt) + (DROP_W+1)'(needW);
   end

   // Entry writes; storage itself needs no reset because ev_count gates reads
   always_ff @(posedge clk) begin
      if (reset && pushEn) begin
         if (regEv) begin
            typeMem[wrPtr] <= 1'b0;
            pcMem[wrPtr]   <= pc;
            addrMem[wrPtr] <= {27'd0, RegAddr};
            dataMem[wrPtr] <= RegData;
         end
         if (memEv) begin
            typeMem[memSlot] <= 1'b1;
            pcMem[memSlot]   <= pc;
            addrMem[memSlot] <= MemAddr;
            dataMem[memSlot] <= MemData;
         end
      end
   end

   // Pointers, occupancy and drop bookkeeping; reset wins over push and pop
   always_ff @(posedge clk) begin
      if (!reset) begin
         wrPtr    <= '0;
         rdPtr    <= '0;
         ev_count <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (pushEn) begin
            wrPtr <= wrPtr + AW'(needW);
         end
         if (popEn) begin
            rdPtr <= rdPtr + 1'b1;
         end
         ev_count <= ev_count + (pushEn ? CW'(needW) : CW'(0)) - CW'(popEn);
         if (dropEn) begin
            overflow <= 1'b1;
            drop_cnt <= dropSum[DROP_W] ? '1 : dropSum[DROP_W-1:0];
         end
      end
   end

   // Fall-through head view, forced to zero while empty
   always_comb begin
      ev_valid = (ev_count != '0);
      ev_type  = 1'b0;
      ev_pc    = '0;
      ev_addr  = '0;
      ev_data  = '0;
      if (ev_valid) begin
         ev_type = typeMem[rdPtr];
         ev_pc   = pcMem[rdPtr];
         ev_addr = addrMem[rdPtr];
         ev_data = dataMem[rdPtr];
      end
   end

endmodule

// File: tb/tb_trace_capture_fifo.sv
// tb_trace_capture_fifo
// Directed scenarios followed by randomized trace traffic. A queue-based
// reference FIFO predicts contents, occupancy and drop counts; a negedge
// monitor pops the expected queue on every accepted head entry.
module tb_trace_capture_fifo;

   localparam int DEPTH  = 16;
   localparam int DROP_W = 16;
   localparam int W      = 97;   // {type, pc, addr, data}
   localparam int DROP_MAX = (1 << DROP_W) - 1;

   logic                   clk;
   logic                   reset;
   logic                   cap_en;
   logic [31:0]            pc;
   logic                   RegWrite;
   logic [4:0]             RegAddr;
   logic [31:0]            RegData;
   logic                   MemWrite;
   logic [31:0]            MemAddr;
   logic [31:0]            MemData;
   logic                   ev_valid;
   logic                   ev_ready;
   logic                   ev_type;
   logic [31:0]            ev_pc;
   logic [31:0]            ev_addr;
   logic [31:0]            ev_data;
   logic [$clog2(DEPTH):0] ev_count;
   logic                   overflow;
   logic [DROP_W-1:0]      drop_cnt;

   trace_capture_fifo #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
      .clk(clk), .reset(reset), .cap_en(cap_en), .pc(pc),
      .RegWrite(RegWrite), .RegAddr(RegAddr), .RegData(RegData),
      .MemWrite(MemWrite), .MemAddr(MemAddr), .MemData(MemData),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_type(ev_type),
      .ev_pc(ev_pc), .ev_addr(ev_addr), .ev_data(ev_data),
      .ev_count(ev_count), .overflow(overflow), .drop_cnt(drop_cnt)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard and reference state
   logic [W-1:0] exp_q[$];
   int  expCount;
   bit  expOvf;
   int  expDrop;
   int  nChecks;
   int  nPass;
   bit  monOn;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      nChecks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else nPass++;
   endtask

   // Monitor: compares every accepted head entry with the expected queue
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (monOn) begin
         if (ev_valid === 1'b1 && ev_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               nChecks++;
               $display("FAIL pop_unexpected: got data %0h expected no entry", ev_data);
            end else begin
               e = exp_q.pop_front();
               chk("ev_type", {127'd0, ev_type}, {127'd0, e[96]});
               chk("ev_pc",   {96'd0, ev_pc},    {96'd0, e[95:64]});
               chk("ev_addr", {96'd0, ev_addr},  {96'd0, e[63:32]});
               chk("ev_data", {96'd0, ev_data},  {96'd0, e[31:0]});
            end
         end else if (ev_valid !== 1'b1) begin
            chk("empty_fields", {31'd0, ev_type, ev_pc, ev_addr, ev_data}, 128'd0);
         end
      end
   end

   // Post-edge checks of occupancy and status against the reference
   task automatic chkState(input string tag);
      chk({tag, "_count"},    {123'd0, ev_count},  128'(expCount));
      chk({tag, "_valid"},    {127'd0, ev_valid},  {127'd0, expCount != 0});
      chk({tag, "_overflow"}, {127'd0, overflow},  {127'd0, expOvf});
      chk({tag, "_drop"},     {112'd0, drop_cnt},  128'(expDrop));
   endtask

   // Driver: one clock of trace-port activity plus the reference update
   task automatic step(input bit ce, input bit rw, input logic [4:0] ra, input logic [31:0] rd,
                       input bit mw, input logic [31:0] ma, input logic [31:0] md,
                       input logic [31:0] pcv, input bit rdy);
      bit regE, memE, popM;
      int need, free;
      reset = 1'b1; cap_en = ce; RegWrite = rw; RegAddr = ra; RegData = rd;
      MemWrite = mw; MemAddr = ma; MemData = md; pc = pcv; ev_ready = rdy;
      popM = (exp_q.size() != 0) && rdy;
      regE = ce && rw && (ra != 5'd0);
      memE = ce && mw;
      need = int'(regE) + int'(memE);
      free = DEPTH - exp_q.size() + int'(popM);
      if (need > free) begin
         expOvf  = 1'b1;
         expDrop = (expDrop + need > DROP_MAX) ? DROP_MAX : expDrop + need;
         expCount = expCount - int'(popM);
      end else begin
         if (regE) exp_q.push_back({1'b0, pcv, 27'd0, ra, rd});
         if (memE) exp_q.push_back({1'b1, pcv, ma, md});
         expCount = expCount + need - int'(popM);
      end
      @(posedge clk);
      #1;
      chkState("step");
   endtask

   task automatic idle(input bit rdy);
      step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, rdy);
   endtask

   // Reset for n edges with a register write present on the trace port
   task automatic doReset(input int n, input bit rdy);
      reset = 1'b0; cap_en = 1'b1; RegWrite = 1'b1; RegAddr = 5'd5; RegData = 32'h55;
      MemWrite = 1'b1; MemAddr = 32'h80; MemData = 32'h66; pc = 32'h100; ev_ready = rdy;
      repeat (n) @(posedge clk);
      #1;
      exp_q.delete();
      expCount = 0; expOvf = 1'b0; expDrop = 0;
      monOn = 1'b1;
      chk("rst_valid", {127'd0, ev_valid}, 128'd0);
      chk("rst_count", {123'd0, ev_count}, 128'd0);
      chk("rst_overflow", {127'd0, overflow}, 128'd0);
      chk("rst_drop", {112'd0, drop_cnt}, 128'd0);
      chk("rst_fields", {31'd0, ev_type, ev_pc, ev_addr, ev_data}, 128'd0);
   endtask

   initial begin
      int pct;
      nChecks = 0; nPass = 0; monOn = 1'b0;
      expCount = 0; expOvf = 1'b0; expDrop = 0;
      reset = 1'b0; cap_en = 1'b0; pc = '0; RegWrite = 1'b0; RegAddr = '0; RegData = '0;
      MemWrite = 1'b0; MemAddr = '0; MemData = '0; ev_ready = 1'b0;

      // T1 reset
      doReset(2, 1'b0);

      // T2 single register write, visible the cycle after sampling
      step(1'b1, 1'b1, 5'd5, 32'h1234, 1'b0, 32'd0, 32'd0, 32'h3000, 1'b1);
      chk("t2_valid", {127'd0, ev_valid}, 128'd1);
      chk("t2_addr", {96'd0, ev_addr}, 128'd5);
      idle(1'b1);
      chk("t2_count_after", {123'd0, ev_count}, 128'd0);

      // T3 $0 filter and cap_en gating
      step(1'b1, 1'b1, 5'd0, 32'hDEAD, 1'b0, 32'd0, 32'd0, 32'h3008, 1'b1);
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 32'h20, 32'hBEEF, 32'h300C, 1'b1);
      chk("t3_count", {123'd0, ev_count}, 128'd0);

      // T4 dual event: reg first, then mem
      step(1'b1, 1'b1, 5'd8, 32'hA, 1'b1, 32'h10, 32'hB, 32'h3004, 1'b0);
      chk("t4_count", {123'd0, ev_count}, 128'd2);
      idle(1'b1);
      idle(1'b1);

      // T5 overflow with the consumer stalled
      for (int i = 1; i <= 17; i++)
         step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 32'h200 + 32'(i), 32'(i), 32'h4000 + 32'(4 * i), 1'b0);
      chk("t5_count", {123'd0, ev_count}, 128'd16);
      chk("t5_overflow", {127'd0, overflow}, 128'd1);
      chk("t5_drop", {112'd0, drop_cnt}, 128'd1);
      step(1'b1, 1'b1, 5'd9, 32'h99, 1'b1, 32'h300, 32'h98, 32'h4100, 1'b0);
      chk("t5_drop_pair", {112'd0, drop_cnt}, 128'd3);
      step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 32'h400, 32'd100, 32'h4104, 1'b1);
      chk("t5_full_pop_push", {123'd0, ev_count}, 128'd16);
      for (int i = 0; i < 16; i++) idle(1'b1);

      // T6 reset mid-operation with entries queued past the wrap point
      for (int i = 0; i < 5; i++)
         step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 32'h500 + 32'(i), 32'h700 + 32'(i), 32'h5000, 1'b0);
      chk("t6_pre_count", {123'd0, ev_count}, 128'd5);
      doReset(1, 1'b1);

      // Randomized traffic with alternating consumer pressure
      for (int i = 0; i < 800; i++) begin
         pct = ((i / 40) % 2 == 1) ? 90 : 15;
         step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
              $urandom, $urandom_range(0, 9) < 4, $urandom, $urandom, $urandom,
              $urandom_range(0, 99) < pct);
      end

      // Drain whatever is left
      for (int i = 0; i < 2 * DEPTH && expCount != 0; i++) idle(1'b1);
      chk("final_count", {123'd0, ev_count}, 128'd0);
      chk("final_sb_empty", 128'(exp_q.size()), 128'd0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
